// File: rtl/div_ctrl.sv
// div_ctrl: issue/writeback controller between EX and the iterative divider.
// Latches one divide request, holds the divider start level, returns a one-cycle writeback.
module div_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [DATA_W-1:0] req_rs1_i,
  input  logic [DATA_W-1:0] req_rs2_i,
  input  logic [ADDR_W-1:0] req_waddr_i,
  input  logic              flush_i,
  output logic              hold_o,
  output logic              div_start_o,
  output logic [DATA_W-1:0] div_dividend_o,
  output logic [DATA_W-1:0] div_divisor_o,
  output logic [2:0]        div_op_o,
  output logic [ADDR_W-1:0] div_waddr_o,
  input  logic [DATA_W-1:0] div_result_i,
  input  logic              div_ready_i,
  input  logic              div_busy_i,
  output logic              wb_valid_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0] wb_data_o
);

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_COOL
  } state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == INST_REM) || (op == INST_REMU);
  endfunction

  function automatic logic is_overflow(input logic [2:0]               op,
                                       input logic signed [DATA_W-1:0] rs1,
                                       input logic signed [DATA_W-1:0] rs2);
    return is_signed_op(op) && (rs1 == SMIN) && (rs2 == '1);
  endfunction

  // Results the divider would produce for the cases it is never asked to compute.
  function automatic logic [DATA_W-1:0] bypass_result(input logic [2:0]        op,
                                                      input logic [DATA_W-1:0] rs1,
                                                      input logic [DATA_W-1:0] rs2);
    logic [DATA_W-1:0] res;
    if (rs2 == '0) begin
      res = is_rem_op(op) ? rs1 : {DATA_W{1'b1}};
    end else if (is_rem_op(op)) begin
      res = '0;
    end else begin
      res = SMIN;
    end
    return res;
  endfunction

  state_e            state_q;
  logic              start_q;
  logic              wb_valid_q;
  logic              bypass_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [ADDR_W-1:0] wb_waddr_q;
  logic [1:0]        busy_lo_q;
  logic [1:0]        busy_lo_d;
  logic              accept;
  logic              req_bypass;

  always_comb begin
    accept     = (state_q == S_IDLE) && req_valid_i && !flush_i;
    req_bypass = (req_rs2_i == '0) ||
                 is_overflow(req_op_i, $signed(req_rs1_i), $signed(req_rs2_i));
    busy_lo_d  = 2'd0;
    if ((state_q == S_RUN) && !div_busy_i) begin
      busy_lo_d = (busy_lo_q == 2'd3) ? 2'd3 : busy_lo_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      bypass_q   <= 1'b0;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      waddr_q    <= '0;
      wb_data_q  <= '0;
      wb_waddr_q <= '0;
      busy_lo_q  <= 2'd0;
    end else begin
      wb_valid_q <= 1'b0;
      busy_lo_q  <= busy_lo_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q       <= req_op_i;
            dividend_q <= req_rs1_i;
            divisor_q  <= req_rs2_i;
            waddr_q    <= req_waddr_i;
            bypass_q   <= req_bypass;
            if (req_bypass) begin
              wb_data_q  <= bypass_result(req_op_i, req_rs1_i, req_rs2_i);
              wb_waddr_q <= req_waddr_i;
              wb_valid_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              start_q <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // A flush outranks a result arriving in the same cycle.
          if (flush_i) begin
            start_q <= 1'b0;
            state_q <= S_COOL;
          end else if (div_ready_i) begin
            wb_data_q  <= div_result_i;
            wb_waddr_q <= waddr_q;
            wb_valid_q <= 1'b1;
            start_q    <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= bypass_q ? S_IDLE : S_COOL;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o    = (state_q == S_IDLE);
  assign hold_o         = (accept && !req_bypass) || ((state_q == S_RUN) && !flush_i);
  assign div_start_o    = start_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign div_op_o       = op_q;
  assign div_waddr_o    = waddr_q;
  assign wb_valid_o     = wb_valid_q && !flush_i;
  assign wb_waddr_o     = wb_waddr_q;
  assign wb_data_o      = wb_data_q;

  // The divider should report busy shortly after seeing start; a long idle stretch means it missed it.
  a_busy_in_run: assert property (@(posedge clk_i) disable iff (rst_i)
    !((state_q == S_RUN) && !div_busy_i && (busy_lo_q == 2'd2)));

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed and randomized divide traffic against a latency-programmable
// divider stand-in and a RISC-V division reference model.
module tb_div_ctrl;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_op_i = 3'd0;
  logic [31:0] req_rs1_i = 32'd0;
  logic [31:0] req_rs2_i = 32'd0;
  logic [4:0]  req_waddr_i = 5'd0;
  logic        flush_i = 1'b0;
  logic        hold_o;
  logic        div_start_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [2:0]  div_op_o;
  logic [4:0]  div_waddr_o;
  logic [31:0] div_result_i;
  logic        div_ready_i;
  logic        div_busy_i;
  logic        wb_valid_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_data_o;

  always #5 clk_i = ~clk_i;

  div_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_rs1_i      (req_rs1_i),
    .req_rs2_i      (req_rs2_i),
    .req_waddr_i    (req_waddr_i),
    .flush_i        (flush_i),
    .hold_o         (hold_o),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_op_o       (div_op_o),
    .div_waddr_o    (div_waddr_o),
    .div_result_i   (div_result_i),
    .div_ready_i    (div_ready_i),
    .div_busy_i     (div_busy_i),
    .wb_valid_o     (wb_valid_o),
    .wb_waddr_o     (wb_waddr_o),
    .wb_data_o      (wb_data_o)
  );

  // RISC-V M-extension division semantics.
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic        [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      r = (op == OP_REM || op == OP_REMU) ? a : 32'hFFFF_FFFF;
    end else if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = (op == OP_DIV) ? 32'h8000_0000 : 32'd0;
    end else begin
      case (op)
        OP_DIV:  r = $unsigned(sa / sb);
        OP_REM:  r = $unsigned(sa % sb);
        OP_DIVU: r = a / b;
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  // Divider stand-in: busy the cycle after start, ready after dv_lat more cycles, cleared by start low.
  int          dv_lat = 0;
  int          dv_cnt = 0;
  logic        dv_busy = 1'b0;
  logic        dv_ready = 1'b0;
  logic [31:0] dv_res = 32'd0;

  always @(posedge clk_i) begin
    if (rst_i || !div_start_o) begin
      dv_busy  <= 1'b0;
      dv_ready <= 1'b0;
    end else if (!dv_busy && !dv_ready) begin
      dv_busy <= 1'b1;
      dv_cnt  <= dv_lat;
    end else if (dv_busy) begin
      if (dv_cnt == 0) begin
        dv_busy  <= 1'b0;
        dv_ready <= 1'b1;
        dv_res   <= ref_div(div_op_o, div_dividend_o, div_divisor_o);
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  assign div_result_i = dv_res;
  assign div_ready_i  = dv_ready;
  assign div_busy_i   = dv_busy;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic        obs_ready0;
  int          obs_wb_cnt, obs_wb_c, obs_start_cnt, obs_start_gap, obs_hold_cnt;
  int          obs_idle_c, obs_unstable;
  logic [31:0] obs_wb_data;
  logic [4:0]  obs_wb_addr;

  // Issues one request at the current (IDLE) cycle and follows it until the controller is idle again.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input int lat,
                        input int flush_at);
    logic [31:0] e_data;
    logic        byp, e_wb, hold_prev, start_low;
    int          e_start, e_hold, e_wbc, e_idle;
    logic [31:0] d0, s0;
    logic [2:0]  o0;
    logic [4:0]  w0;
    d0 = '0; s0 = '0; o0 = '0; w0 = '0; start_low = 1'b0;
    dv_lat = lat;

    e_data = ref_div(op, a, b);
    byp    = (b == 32'd0) || ((op == OP_DIV || op == OP_REM) &&
                              a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (byp) begin
      e_start = 0; e_hold = 0; e_wb = (flush_at != 1); e_wbc = 1; e_idle = 2;
    end else if (flush_at >= 1 && flush_at <= lat + 3) begin
      e_start = flush_at; e_hold = flush_at; e_wb = 1'b0; e_wbc = 0; e_idle = flush_at + 2;
    end else begin
      e_start = lat + 3; e_hold = lat + 4; e_wb = (flush_at != lat + 4); e_wbc = lat + 4;
      e_idle = lat + 6;
    end

    obs_wb_cnt = 0; obs_wb_c = 0; obs_start_cnt = 0; obs_start_gap = 0; obs_hold_cnt = 0;
    obs_idle_c = -1; obs_unstable = 0; obs_wb_data = '0; obs_wb_addr = '0;

    req_valid_i = 1'b1; req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_waddr_i = wa;
    flush_i = 1'b0;
    #1;
    obs_ready0 = req_ready_o;
    if (hold_o) obs_hold_cnt++;
    hold_prev = hold_o;

    for (int c = 1; c <= 200; c++) begin
      if (obs_idle_c >= 0) break;
      @(negedge clk_i);
      // EX keeps presenting under hold; operands change to prove they were latched.
      req_valid_i = hold_prev;
      req_op_i    = 3'($urandom);
      req_rs1_i   = $urandom;
      req_rs2_i   = $urandom;
      req_waddr_i = 5'($urandom);
      flush_i     = (c == flush_at);
      #1;
      if (hold_o) obs_hold_cnt++;
      if (div_start_o) begin
        if (obs_start_cnt == 0) begin
          d0 = div_dividend_o; s0 = div_divisor_o; o0 = div_op_o; w0 = div_waddr_o;
        end else if (div_dividend_o !== d0 || div_divisor_o !== s0 ||
                     div_op_o !== o0 || div_waddr_o !== w0) begin
          obs_unstable++;
        end
        if (start_low) obs_start_gap++;
        obs_start_cnt++;
      end else if (obs_start_cnt > 0) begin
        start_low = 1'b1;
      end
      if (wb_valid_o) begin
        obs_wb_cnt++;
        obs_wb_c    = c;
        obs_wb_data = wb_data_o;
        obs_wb_addr = wb_waddr_o;
      end
      if (req_ready_o) obs_idle_c = c;
      hold_prev = hold_o;
    end
    req_valid_i = 1'b0;
    flush_i     = 1'b0;

    check({nm, ".ready_at_issue"}, 64'(obs_ready0), 64'(1'b1));
    check({nm, ".idle_cycle"}, 64'(obs_idle_c), 64'(e_idle));
    check({nm, ".start_cycles"}, 64'(obs_start_cnt), 64'(e_start));
    check({nm, ".hold_cycles"}, 64'(obs_hold_cnt), 64'(e_hold));
    check({nm, ".start_gap"}, 64'(obs_start_gap), 64'(0));
    check({nm, ".wb_count"}, 64'(obs_wb_cnt), e_wb ? 64'(1) : 64'(0));
    if (e_wb) begin
      check({nm, ".wb_data"}, 64'(obs_wb_data), 64'(e_data));
      check({nm, ".wb_addr"}, 64'(obs_wb_addr), 64'(wa));
      check({nm, ".wb_cycle"}, 64'(obs_wb_c), 64'(e_wbc));
    end
    if (e_start > 0) begin
      check({nm, ".div_dividend"}, 64'(d0), 64'(a));
      check({nm, ".div_divisor"}, 64'(s0), 64'(b));
      check({nm, ".div_op"}, 64'(o0), 64'(op));
      check({nm, ".div_waddr"}, 64'(w0), 64'(wa));
      check({nm, ".operand_stable"}, 64'(obs_unstable), 64'(0));
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".req_ready"}, 64'(req_ready_o), 64'(1'b1));
    check({nm, ".hold"}, 64'(hold_o), 64'(1'b0));
    check({nm, ".div_start"}, 64'(div_start_o), 64'(1'b0));
    check({nm, ".wb_valid"}, 64'(wb_valid_o), 64'(1'b0));
    check({nm, ".wb_data"}, 64'(wb_data_o), 64'(0));
    check({nm, ".wb_waddr"}, 64'(wb_waddr_o), 64'(0));
    check({nm, ".div_operands"},
          {div_dividend_o, div_divisor_o}, 64'(0));
    check({nm, ".div_op_waddr"}, 64'({div_op_o, div_waddr_o}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb_seen, start_seen;

    repeat (3) @(negedge clk_i);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd3, 34, -1);
    check("divu_100_7.literal", 64'(obs_wb_data), 64'(32'd14));

    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 5, -1);
    check("rem_m7_2.literal", 64'(obs_wb_data), 64'(32'hFFFF_FFFF));
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 5, -1);
    check("div_m7_2.literal", 64'(obs_wb_data), 64'(32'hFFFF_FFFD));

    run_op("div_by_zero", OP_DIV, 32'd5, 32'd0, 5'd6, 5, -1);
    check("div_by_zero.literal", 64'(obs_wb_data), 64'(32'hFFFF_FFFF));
    run_op("remu_by_zero", OP_REMU, 32'd5, 32'd0, 5'd7, 5, -1);
    check("remu_by_zero.literal", 64'(obs_wb_data), 64'(32'd5));

    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 5, -1);
    check("div_ovf.literal", 64'(obs_wb_data), 64'(32'h8000_0000));
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 5, -1);
    check("rem_ovf.literal", 64'(obs_wb_data), 64'(32'd0));

    run_op("flush_in_run", OP_DIVU, 32'd1000, 32'd3, 5'd10, 34, 11);
    run_op("after_flush", OP_DIVU, 32'd9, 32'd3, 5'd11, 6, -1);
    check("after_flush.literal", 64'(obs_wb_data), 64'(32'd3));

    run_op("flush_with_ready", OP_DIVU, 32'd50, 32'd5, 5'd12, 4, 7);
    run_op("flush_in_done", OP_DIVU, 32'd50, 32'd5, 5'd13, 4, 8);
    run_op("flush_bypass_done", OP_DIVU, 32'd7, 32'd0, 5'd14, 4, 1);

    // A flush in IDLE blocks acceptance.
    req_valid_i = 1'b1; req_op_i = OP_DIVU; req_rs1_i = 32'd8; req_rs2_i = 32'd2;
    req_waddr_i = 5'd15; flush_i = 1'b1;
    #1;
    check("flush_idle.hold", 64'(hold_o), 64'(1'b0));
    @(negedge clk_i);
    req_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    check("flush_idle.ready", 64'(req_ready_o), 64'(1'b1));
    check("flush_idle.start", 64'(div_start_o), 64'(1'b0));

    // Reset in the middle of a long division.
    @(negedge clk_i);
    dv_lat = 30;
    req_valid_i = 1'b1; req_op_i = OP_DIVU; req_rs1_i = 32'd1000; req_rs2_i = 32'd3;
    req_waddr_i = 5'd9;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    #1;
    check("rst_mid.pre_start", 64'(div_start_o), 64'(1'b1));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk_i);
    rst_i = 1'b0;
    wb_seen = 0; start_seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      #1;
      if (wb_valid_o) wb_seen++;
      if (div_start_o) start_seen++;
    end
    check("rst_mid.no_wb", 64'(wb_seen), 64'(0));
    check("rst_mid.no_restart", 64'(start_seen), 64'(0));

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          rl, rf;
      rop = 3'($urandom_range(4, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'd0;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        3: ra = 32'($urandom_range(1, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        3: rb = 32'($urandom_range(2, 20));
        default: rb = $urandom;
      endcase
      rl = int'($urandom_range(0, 12));
      rf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rl + 5)) : -1;
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom), rl, rf);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Issue/writeback controller between the EX stage and the iterative divider. It accepts one DIV/DIVU/REM/REMU request from EX and stalls the pipeline while the divider runs. It holds the divider's start level for the whole operation and returns the result as a one-cycle writeback pulse. Divide-by-zero and signed overflow bypass the divider, and a pipeline flush cancels an in-flight division.

Parameters:
DATA_W, 32, operand/result width (matches RegBus)
ADDR_W, 5, register address width (matches RegAddrBus)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
req_valid_i  in  1  EX presents a divide instruction
req_ready_o  out  1  controller can accept (state IDLE)
req_op_i  in  3  funct3: INST_DIV/DIVU/REM/REMU from tinyriscv_pkg
req_rs1_i  in  DATA_W  dividend
req_rs2_i  in  DATA_W  divisor
req_waddr_i  in  ADDR_W  destination register
flush_i  in  1  pipeline flush; cancels pending operation
hold_o  out  1  stall request to pipeline control
div_start_o  out  1  divider start level, held for whole operation
div_dividend_o  out  DATA_W  latched dividend
div_divisor_o  out  DATA_W  latched divisor
div_op_o  out  3  latched op
div_waddr_o  out  ADDR_W  latched destination
div_result_i  in  DATA_W  divider result
div_ready_i  in  1  divider result valid (registered level)
div_busy_i  in  1  divider busy
wb_valid_o  out  1  one-cycle writeback strobe
wb_waddr_o  out  ADDR_W  writeback register
wb_data_o  out  DATA_W  writeback data

Behaviour:
- Reset (sync, rst_i=1): state IDLE. All outputs 0 except req_ready_o=1. Latched operands cleared. Reset mid-operation drops div_start_o on the next edge with no writeback.
- States: IDLE, RUN, DONE, COOL.
- IDLE: accept when req_valid_i & ~flush_i. Latch op/rs1/rs2/waddr.
  - Bypass case: rs2==0, or signed overflow (op DIV/REM, rs1=0x8000_0000, rs2=0xFFFF_FFFF). Go to DONE with data precomputed; divider is never started.
    - Zero divisor: DIV/DIVU -> 0xFFFF_FFFF; REM/REMU -> rs1.
    - Overflow: DIV -> 0x8000_0000; REM -> 0.
  - Otherwise go to RUN with div_start_o=1 from the next cycle.
- RUN: div_start_o=1, operand outputs stable. When div_ready_i=1, capture div_result_i into wb_data, drop div_start_o, go to DONE. Latency is set by the divider (~35 cycles); no fixed count is assumed.
- DONE: wb_valid_o=1 for exactly one cycle with wb_waddr_o/wb_data_o, then go to COOL.
- COOL: div_start_o=0 for one cycle so the divider returns to idle and clears its ready level, then go to IDLE. Bypass paths skip COOL and return from DONE to IDLE.
- hold_o:
  - Combinational 1 in IDLE when a non-bypass request is accepted, and in RUN.
  - 0 in DONE, COOL and IDLE otherwise.
  - A bypass request in IDLE stalls for 0 cycles.
- req_ready_o=1 only in IDLE. A req_valid_i while not ready is ignored; EX keeps presenting it under hold.
- flush_i:
  - In RUN: drop div_start_o, go to COOL, no writeback, hold_o=0 that cycle.
  - In DONE: suppress wb_valid_o.
  - In IDLE: blocks acceptance.
  - flush_i together with div_ready_i: flush wins.
- Operands are latched; later changes on req_* do not affect an operation in flight.
- div_busy_i is monitor-only. An assertion flags div_busy_i=0 in RUN for more than 2 consecutive cycles after entry.

Test Plan:
- DIVU 100/7 -> hold_o high until result; exactly one wb_valid_o with data 14, correct waddr; div_start_o continuous through RUN; req_ready_o low in RUN/DONE/COOL.
- REM rs1=-7 (0xFFFF_FFF9), rs2=2 -> wb_data 0xFFFF_FFFF. DIV same operands -> 0xFFFF_FFFD. Back-to-back: the second start follows one COOL cycle with div_start_o=0.
- DIV by zero rs1=5 -> wb_valid the cycle after acceptance, data 0xFFFF_FFFF, div_start_o never high, hold_o never high. REMU by zero -> data 5.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> bypass, data 0x8000_0000. REM same operands -> 0.
- DIVU 1000/3 with flush_i pulsed 10 cycles into RUN -> div_start_o low next cycle, no wb_valid_o, back to IDLE after COOL. Next request 9/3 -> 3.
- rst_i asserted mid-RUN -> all outputs at reset values on the next edge. Flush coincident with div_ready_i -> no writeback.
